fpu_top: RTL and testbench
==========================

Name: fpu_top

Overview:
- Single-precision IEEE-754 floating-point unit executing ADD, MUL and DIV on two 32-bit operands.
- One operation in flight at a time, started by a one-cycle dval strobe; completion signalled by a one-cycle rdy pulse.
- Sits as a memory/command-mapped accelerator; the host holds cmd/din stable only in the dval cycle.

Parameters:
- DIV_ITER, 26, quotient bits produced by iterative divider (24 significand + guard + round); sticky taken from remainder.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  reset: synchronous, active-high (1 = reset, sampled on clk rising edge).
- cmd  input  4  operation: 4'b0001 ADD, 4'b0010 MUL, 4'b0011 DIV; other codes unsupported.
- din1  input  32  operand A (IEEE-754 binary32).
- din2  input  32  operand B (divisor for DIV).
- dval  input  1  operation start strobe; cmd/din1/din2 captured when high and unit idle.
- result  output  32  A+B, A*B or A/B; registered, held until next completion.
- rdy  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset: result=32'h0, rdy=0, FSM=IDLE; reset mid-operation aborts it, no rdy.
- FSM: IDLE -> UNPACK -> EXEC -> NORM -> PACK(rdy) -> IDLE.
  - EXEC is 1 cycle for ADD/MUL and DIV_ITER cycles for DIV.
- Latency: dval sampled at edge T0; rdy high for the cycle following edge T0+4 (ADD, MUL) or T0+29 (DIV).
- Control:
  - dval while not IDLE is ignored.
  - dval with an unsupported cmd is ignored: no rdy, result unchanged.
  - Back-to-back ops are allowed: dval may be asserted in the rdy cycle (unit is IDLE then).
- Unpack:
  - Exponent 0 (zero/denormal) is treated as signed zero (flush-to-zero inputs).
  - Exponent 255: mantissa != 0 is NaN, else inf.
- ADD:
  - Align the smaller-exponent significand by right shift with guard/round/sticky; add or subtract by signs; normalize via leading-zero count.
  - Exact zero difference gives +0.
  - Specials: NaN in -> NaN; inf + -inf -> NaN; inf + finite -> that inf.
- MUL:
  - 24x24 significand product; exponent = eA + eB - 127; sign = XOR.
  - Specials: NaN in -> NaN; inf*0 -> NaN; inf*x -> signed inf; 0*finite -> signed 0.
- DIV:
  - Restoring division of significands; exponent = eA - eB + 127; sign = XOR.
  - Specials: 0/0 and inf/inf -> NaN; x/0 (x != 0) -> signed inf; x/inf -> signed 0; 0/x -> signed 0.
- Rounding: round-to-nearest-even on guard/round/sticky; mantissa carry-out increments the exponent.
- Range:
  - Biased exponent > 254 after rounding -> signed inf (32'h7F800000 / 32'hFF800000).
  - Biased exponent < 1 -> signed zero (no denormal outputs).
- NaN output is always canonical 32'h7FC00000.

Decomposition:
- Package fpu_pkg:
  - cmd code localparams (CMD_FPU_ADD/MUL/DIV).
  - EXP_W=8, MAN_W=23, BIAS=127.
  - QNAN=32'h7FC00000, POS_INF/NEG_INF constants.
  - Unpacked-operand struct {sign, exp[9:0] signed, sig[23:0], is_zero, is_inf, is_nan}.
  - FSM state enum.
- Sub-module fpu_norm_round: normalize, round-nearest-even, overflow/underflow saturation and packing; shared by all three ops.

Test Plan:
- ADD 32'h3F000000 + 32'hBEE00000 (0.5 + -0.4375) -> result 32'h3D800000, rdy at T0+4.
- MUL 32'h3F000000 * 32'hBEE00000 -> 32'hBE600000; MUL 32'h7F7FFFFF * 32'h40000000 -> 32'h7F800000 (overflow).
- DIV 32'h3F800000 / 32'h40400000 (1/3) -> 32'h3EAAAAAB, rdy at T0+29; DIV 32'h3F800000 / 32'h00000000 -> 32'h7F800000.
- Specials: 0/0 -> 32'h7FC00000; 32'h7F800000 + 32'hFF800000 -> 32'h7FC00000; 32'h7F800000 * 0 -> 32'h7FC00000.
- Rounding tie: ADD 32'h3F800000 + 32'h33800000 -> 32'h3F800000; ADD 32'h3F800000 + 32'h3F800000 -> 32'h40000000.
- Control: dval during busy DIV ignored (one rdy only); cmd=0 with dval -> no rdy; rst_n=1 mid-DIV -> rdy stays 0, result=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the single-precision FPU: command codes, operand
// record, FSM states and small combinational helpers.
package fpu_pkg;

    localparam logic [3:0] CMD_FPU_ADD = 4'b0001;
    localparam logic [3:0] CMD_FPU_MUL = 4'b0010;
    localparam logic [3:0] CMD_FPU_DIV = 4'b0011;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        logic [23:0]       sig;
        logic              is_zero;
        logic              is_inf;
        logic              is_nan;
    } fpu_operand_t;

    typedef enum logic [2:0] {StIdle, StUnpack, StExec, StNorm, StPack} fpu_state_e;

    // Denormal inputs are flushed: exponent 0 always reads as a signed zero.
    function automatic fpu_operand_t fpu_unpack(input logic [31:0] v);
        fpu_operand_t     op;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e          = v[MAN_W +: EXP_W];
        m          = v[MAN_W-1:0];
        op.sign    = v[31];
        op.is_zero = (e == '0);
        op.is_inf  = (e == '1) && (m == '0);
        op.is_nan  = (e == '1) && (m != '0);
        op.exp     = (e == '0) ? 10'sd0 : {2'b00, e};
        op.sig     = (e == '0) ? 24'd0 : {1'b1, m};
        return op;
    endfunction

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) n = 6'(47 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_norm_round.sv
// Normalize a 48-bit significand (value = mant/2^46 * 2^(exp-127)), round to nearest even,
// saturate out-of-range exponents and pack to binary32. Specials take priority.
module fpu_norm_round
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic signed [9:0] exp_i,
    input  logic [47:0]       mant_i,
    input  logic              sticky_i,
    input  logic              nan_i,
    input  logic              inf_i,
    input  logic              zero_i,
    output logic [31:0]       res_o
);

    logic [5:0]         lz;
    logic [47:0]        mant_n;
    logic signed [11:0] e_norm;
    logic signed [11:0] e_final;
    logic               round_up;
    logic [24:0]        sig_r;
    logic [22:0]        frac;

    always_comb begin
        lz       = lzc48(mant_i);
        mant_n   = mant_i << lz;
        // Leading one lands on bit 47, one place above the nominal binary point.
        e_norm   = {{2{exp_i[9]}}, exp_i} + 12'd1 - {6'd0, lz};
        round_up = mant_n[23] & (mant_n[24] | (|mant_n[22:0]) | sticky_i);
        sig_r    = {1'b0, mant_n[47:24]} + {24'd0, round_up};
        e_final  = e_norm + {11'd0, sig_r[24]};
        frac     = sig_r[24] ? sig_r[23:1] : sig_r[22:0];

        if (nan_i) begin
            res_o = QNAN;
        end else if (inf_i) begin
            res_o = sign_i ? NEG_INF : POS_INF;
        end else if (zero_i || (mant_i == '0)) begin
            res_o = {sign_i, 31'd0};
        end else if (e_final > 12'sd254) begin
            res_o = sign_i ? NEG_INF : POS_INF;
        end else if (e_final < 12'sd1) begin
            res_o = {sign_i, 31'd0};
        end else begin
            res_o = {sign_i, e_final[7:0], frac};
        end
    end

endmodule

// File: rtl/fpu_top.sv
// Multi-cycle binary32 ADD/MUL/DIV unit: IDLE -> UNPACK -> EXEC -> NORM -> PACK.
// One operation in flight; result is registered and rdy pulses for one cycle.
module fpu_top
    import fpu_pkg::*;
#(
    parameter int unsigned DIV_ITER = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  cmd,
    input  logic [31:0] din1,
    input  logic [31:0] din2,
    input  logic        dval,
    output logic [31:0] result,
    output logic        rdy
);

    localparam int unsigned CNT_W = $clog2(DIV_ITER);

    fpu_state_e        state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [31:0]       din1_q, din1_d, din2_q, din2_d;
    fpu_operand_t      opa_q, opa_d, opb_q, opb_d, ua, ub;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [24:0]       rem_q, rem_d;
    logic [DIV_ITER-1:0] quo_q, quo_d;

    logic              n_sign_q, n_sign_d, n_sticky_q, n_sticky_d;
    logic              n_nan_q, n_nan_d, n_inf_q, n_inf_d, n_zero_q, n_zero_d;
    logic signed [9:0] n_exp_q, n_exp_d;
    logic [47:0]       n_mant_q, n_mant_d;
    logic [31:0]       pack_res_q, pack_res_d, result_q, result_d, norm_res;
    logic              rdy_q, rdy_d;

    logic              a_big, big_sign;
    logic signed [9:0] big_exp, small_exp;
    logic [23:0]       big_sig, small_sig;
    logic [7:0]        add_shift;
    logic [93:0]       add_wide;
    logic              add_sticky, add_sign;
    logic [46:0]       add_small;
    logic [47:0]       add_sum, mul_prod, div_mant;
    logic              div_ge;
    logic [24:0]       div_rem_sub, div_rem_next;
    logic [DIV_ITER-1:0] div_quo_next;
    logic              exec_done, exec_sign, exec_sticky, exec_nan, exec_inf, exec_zero;
    logic signed [9:0] exec_exp;
    logic [47:0]       exec_mant;

    assign ua = fpu_unpack(din1_q);
    assign ub = fpu_unpack(din2_q);

    always_comb begin
        // ADD: order operands by magnitude so the subtraction never goes negative.
        a_big = (opa_q.exp > opb_q.exp) ||
                ((opa_q.exp == opb_q.exp) && (opa_q.sig >= opb_q.sig));
        big_sign  = a_big ? opa_q.sign : opb_q.sign;
        big_exp   = a_big ? opa_q.exp : opb_q.exp;
        big_sig   = a_big ? opa_q.sig : opb_q.sig;
        small_exp = a_big ? opb_q.exp : opa_q.exp;
        small_sig = a_big ? opb_q.sig : opa_q.sig;
        add_shift = big_exp[7:0] - small_exp[7:0];
        add_wide  = {small_sig, 23'd0, 47'd0} >> add_shift;
        add_sticky = (add_shift >= 8'd48) ? (|small_sig) : (|add_wide[46:0]);
        add_small = add_wide[93:47] | {46'd0, add_sticky};
        add_sum   = (opa_q.sign ^ opb_q.sign) ? {1'b0, big_sig, 23'd0} - {1'b0, add_small}
                                              : {1'b0, big_sig, 23'd0} + {1'b0, add_small};
        add_sign  = (add_sum == '0) ? (opa_q.sign & opb_q.sign) : big_sign;

        mul_prod = opa_q.sig * opb_q.sig;

        // DIV: one restoring step per EXEC cycle; leftover remainder feeds sticky.
        div_ge       = rem_q >= {1'b0, opb_q.sig};
        div_rem_sub  = div_ge ? rem_q - {1'b0, opb_q.sig} : rem_q;
        div_rem_next = div_rem_sub << 1;
        div_quo_next = (quo_q << 1) | {{(DIV_ITER-1){1'b0}}, div_ge};
        div_mant     = 48'(div_quo_next) << (47 - DIV_ITER);

        exec_done = (cmd_q != CMD_FPU_DIV) || (cnt_q == CNT_W'(DIV_ITER - 1));

        exec_sign   = (opa_q.is_inf | opb_q.is_inf) ?
                      (opa_q.is_inf ? opa_q.sign : opb_q.sign) : add_sign;
        exec_exp    = big_exp;
        exec_mant   = add_sum;
        exec_sticky = 1'b0;
        exec_nan    = opa_q.is_nan | opb_q.is_nan |
                      (opa_q.is_inf & opb_q.is_inf & (opa_q.sign ^ opb_q.sign));
        exec_inf    = opa_q.is_inf | opb_q.is_inf;
        exec_zero   = 1'b0;
        case (cmd_q)
            CMD_FPU_MUL: begin
                exec_sign   = opa_q.sign ^ opb_q.sign;
                exec_exp    = opa_q.exp + opb_q.exp - 10'(BIAS);
                exec_mant   = mul_prod;
                exec_nan    = opa_q.is_nan | opb_q.is_nan |
                              (opa_q.is_inf & opb_q.is_zero) | (opb_q.is_inf & opa_q.is_zero);
                exec_inf    = opa_q.is_inf | opb_q.is_inf;
                exec_zero   = opa_q.is_zero | opb_q.is_zero;
            end
            CMD_FPU_DIV: begin
                exec_sign   = opa_q.sign ^ opb_q.sign;
                exec_exp    = opa_q.exp - opb_q.exp + 10'(BIAS);
                exec_mant   = div_mant;
                exec_sticky = |div_rem_sub;
                exec_nan    = opa_q.is_nan | opb_q.is_nan |
                              (opa_q.is_zero & opb_q.is_zero) | (opa_q.is_inf & opb_q.is_inf);
                exec_inf    = opb_q.is_zero | opa_q.is_inf;
                exec_zero   = opb_q.is_inf | opa_q.is_zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        din1_d     = din1_q;
        din2_d     = din2_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        n_sign_d   = n_sign_q;
        n_exp_d    = n_exp_q;
        n_mant_d   = n_mant_q;
        n_sticky_d = n_sticky_q;
        n_nan_d    = n_nan_q;
        n_inf_d    = n_inf_q;
        n_zero_d   = n_zero_q;
        pack_res_d = pack_res_q;
        result_d   = result_q;
        rdy_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (dval && ((cmd == CMD_FPU_ADD) || (cmd == CMD_FPU_MUL) ||
                             (cmd == CMD_FPU_DIV))) begin
                    cmd_d   = cmd;
                    din1_d  = din1;
                    din2_d  = din2;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                opa_d   = ua;
                opb_d   = ub;
                cnt_d   = '0;
                rem_d   = {1'b0, ua.sig};
                quo_d   = '0;
                state_d = StExec;
            end
            StExec: begin
                if (cmd_q == CMD_FPU_DIV) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rem_d = div_rem_next;
                    quo_d = div_quo_next;
                end
                if (exec_done) begin
                    n_sign_d   = exec_sign;
                    n_exp_d    = exec_exp;
                    n_mant_d   = exec_mant;
                    n_sticky_d = exec_sticky;
                    n_nan_d    = exec_nan;
                    n_inf_d    = exec_inf;
                    n_zero_d   = exec_zero;
                    state_d    = StNorm;
                end
            end
            StNorm: begin
                pack_res_d = norm_res;
                state_d    = StPack;
            end
            StPack: begin
                result_d = pack_res_q;
                rdy_d    = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    fpu_norm_round u_norm_round (
        .sign_i   (n_sign_q),
        .exp_i    (n_exp_q),
        .mant_i   (n_mant_q),
        .sticky_i (n_sticky_q),
        .nan_i    (n_nan_q),
        .inf_i    (n_inf_q),
        .zero_i   (n_zero_q),
        .res_o    (norm_res)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            din1_q     <= '0;
            din2_q     <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            n_sign_q   <= 1'b0;
            n_exp_q    <= '0;
            n_mant_q   <= '0;
            n_sticky_q <= 1'b0;
            n_nan_q    <= 1'b0;
            n_inf_q    <= 1'b0;
            n_zero_q   <= 1'b0;
            pack_res_q <= '0;
            result_q   <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            din1_q     <= din1_d;
            din2_q     <= din2_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            n_sign_q   <= n_sign_d;
            n_exp_q    <= n_exp_d;
            n_mant_q   <= n_mant_d;
            n_sticky_q <= n_sticky_d;
            n_nan_q    <= n_nan_d;
            n_inf_q    <= n_inf_d;
            n_zero_q   <= n_zero_d;
            pack_res_q <= pack_res_d;
            result_q   <= result_d;
            rdy_q      <= rdy_d;
        end
    end

    assign result = result_q;
    assign rdy    = rdy_q;

endmodule

// File: tb/tb_fpu_top.sv
// Directed bench for fpu_top: hand-computed binary32 results, latency and control cases.
module tb_fpu_top;

    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] MUL = 4'b0010;
    localparam logic [3:0] DIV = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cmd;
    logic [31:0] din1, din2, result;
    logic        dval, rdy;

    int n_cmp = 0;
    int n_err = 0;

    fpu_top #(.DIV_ITER(26)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmd    (cmd),
        .din1   (din1),
        .din2   (din2),
        .dval   (dval),
        .result (result),
        .rdy    (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd  = c;
        din1 = a;
        din2 = b;
        dval = 1'b1;
        @(posedge clk);
        #1;
        dval = 1'b0;
        cmd  = 4'd0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        lat = 0;
        start_op(c, a, b);
        while (!rdy && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, rdy}, 32'd0);
    endtask

    task automatic watch(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rdy) pulses++;
        end
    endtask

    initial begin
        int pulses, first_lat;
        logic [31:0] seen_res;

        rst_n = 1'b1;
        dval  = 1'b0;
        cmd   = 4'd0;
        din1  = '0;
        din2  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_rdy", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        do_op("add_half", ADD, 32'h3F000000, 32'hBEE00000, 32'h3D800000, 4);
        do_op("mul_half", MUL, 32'h3F000000, 32'hBEE00000, 32'hBE600000, 4);
        do_op("mul_ovf", MUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4);
        do_op("div_third", DIV, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29);
        do_op("div_by0", DIV, 32'h3F800000, 32'h00000000, 32'h7F800000, 29);
        do_op("div_0by0", DIV, 32'h00000000, 32'h00000000, 32'h7FC00000, 29);
        do_op("add_infs", ADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4);
        do_op("mul_inf0", MUL, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4);
        do_op("add_tie_even", ADD, 32'h3F800000, 32'h33800000, 32'h3F800000, 4);
        do_op("add_one_one", ADD, 32'h3F800000, 32'h3F800000, 32'h40000000, 4);
        do_op("add_tie_odd", ADD, 32'h3F800001, 32'h33800000, 32'h3F800002, 4);
        do_op("add_sub", ADD, 32'h40400000, 32'hBF800000, 32'h40000000, 4);
        do_op("add_cancel", ADD, 32'hBF800000, 32'h3F800000, 32'h00000000, 4);
        do_op("add_denorm", ADD, 32'h00000001, 32'h3F800000, 32'h3F800000, 4);
        do_op("add_nan", ADD, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 4);
        do_op("mul_1p5x2", MUL, 32'h3FC00000, 32'h40000000, 32'h40400000, 4);
        do_op("mul_uflow", MUL, 32'h0D800000, 32'h0D800000, 32'h00000000, 4);
        do_op("div_6by2", DIV, 32'h40C00000, 32'h40000000, 32'h40400000, 29);
        do_op("div_byinf", DIV, 32'hBF800000, 32'h7F800000, 32'h80000000, 29);

        // A second dval while the divider is busy must not start anything.
        start_op(DIV, 32'h3F800000, 32'h40400000);
        pulses    = 0;
        first_lat = 0;
        seen_res  = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            dval = (i == 5);
            cmd  = (i == 5) ? ADD : 4'd0;
            din1 = 32'h3F800000;
            din2 = 32'h3F800000;
            @(posedge clk);
            #1;
            dval = 1'b0;
            if (rdy) begin
                pulses++;
                if (first_lat == 0) first_lat = i;
                seen_res = result;
            end
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_lat", 32'(first_lat), 32'd29);
        check("busy_res", seen_res, 32'h3EAAAAAB);

        start_op(4'd0, 32'h3F800000, 32'h3F800000);
        watch(40, pulses);
        check("badcmd_pulses", 32'(pulses), 32'd0);
        check("badcmd_res", result, 32'h3EAAAAAB);

        // Back-to-back: next dval lands in the rdy cycle of the previous op.
        start_op(ADD, 32'h3F800000, 32'h3F800000);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("b2b_rdy1", {31'd0, rdy}, 32'd1);
        check("b2b_res1", result, 32'h40000000);
        start_op(MUL, 32'h3FC00000, 32'h40000000);
        check("b2b_gap", {31'd0, rdy}, 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("b2b_rdy2", {31'd0, rdy}, 32'd1);
        check("b2b_res2", result, 32'h40400000);

        start_op(DIV, 32'h3F800000, 32'h40400000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        watch(40, pulses);
        check("rst_pulses", 32'(pulses), 32'd0);
        check("rst_res", result, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
